// File: rtl/delimiter_detect.sv
// delimiter_detect: MVB receive-side delimiter hunter and Manchester decoder.
//   Hunts the half-bit line stream for the 18-half-bit master/slave start
//   delimiters, then decodes data pairs (10 -> 1, 01 -> 0) until the
//   0110 + 00 frame-end delimiter, flagging code violations and overlong frames.
//
// Ports:
//   clk_3M        half-bit clock, rising edge
//   reset         asynchronous active-high reset
//   rx_enable     receiver enable; low forces HUNT and clears the shift register
//   line_in       synchronised line sample, one half-bit per clock
//   master_start  pulse: master start delimiter detected
//   slave_start   pulse: slave start delimiter detected
//   data_out      decoded data bit, qualified by data_valid
//   data_valid    pulse per emitted data bit
//   frame_end     pulse: clean frame end
//   frame_err     pulse: code violation or length timeout
//   in_frame      high while decoding a frame
//   bit_count     data bits emitted in the current or last frame
//   err_count     (only with DELIM_ERRCNT_EN) saturating frame_err counter
//
// Optional feature macro: DELIM_ERRCNT_EN adds the err_count output.

module delimiter_detect #(
    parameter int unsigned MAX_BITS = 300
) (
    input  logic       clk_3M,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       line_in,
    output logic       master_start,
    output logic       slave_start,
    output logic       data_out,
    output logic       data_valid,
    output logic       frame_end,
    output logic       frame_err,
    output logic       in_frame,
    output logic [8:0] bit_count
`ifdef DELIM_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int unsigned SR_W  = 18;
    localparam int unsigned CNT_W = 9;

    localparam logic [SR_W-1:0] MASTER_PAT = 18'b11_10_01_00_10_01_00_00_00;
    localparam logic [SR_W-1:0] SLAVE_PAT  = 18'b11_11_11_11_01_10_11_01_10;
    localparam logic [3:0]      END_PAT    = 4'b0110;

    localparam logic [0:0] ST_HUNT     = 1'b0;
    localparam logic [0:0] ST_IN_FRAME = 1'b1;

    logic [0:0]      state, state_nxt;
    logic [SR_W-1:0] sr, sr_nxt;
    logic            phase, phase_nxt;
    // dbuf[1] is the oldest withheld bit once dbuf_cnt reaches 2
    logic [1:0]      dbuf, dbuf_nxt;
    logic [1:0]      dbuf_cnt, dbuf_cnt_nxt;

    logic             master_start_nxt;
    logic             slave_start_nxt;
    logic             data_out_nxt;
    logic             data_valid_nxt;
    logic             frame_end_nxt;
    logic             frame_err_nxt;
    logic             in_frame_nxt;
    logic [CNT_W-1:0] bit_count_nxt;
`ifdef DELIM_ERRCNT_EN
    logic [7:0]       err_count_nxt;
`endif

    // Next-state, decode and output logic
    always_comb begin
        sr_nxt           = {sr[SR_W-2:0], line_in};
        state_nxt        = state;
        phase_nxt        = phase;
        dbuf_nxt         = dbuf;
        dbuf_cnt_nxt     = dbuf_cnt;
        bit_count_nxt    = bit_count;
        data_out_nxt     = data_out;
        master_start_nxt = 1'b0;
        slave_start_nxt  = 1'b0;
        data_valid_nxt   = 1'b0;
        frame_end_nxt    = 1'b0;
        frame_err_nxt    = 1'b0;

        if (!rx_enable) begin
            sr_nxt       = '0;
            state_nxt    = ST_HUNT;
            phase_nxt    = 1'b0;
            dbuf_nxt     = '0;
            dbuf_cnt_nxt = '0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (sr_nxt == MASTER_PAT || sr_nxt == SLAVE_PAT) begin
                        master_start_nxt = (sr_nxt == MASTER_PAT);
                        slave_start_nxt  = (sr_nxt == SLAVE_PAT);
                        bit_count_nxt    = '0;
                        phase_nxt        = 1'b0;
                        dbuf_nxt         = '0;
                        dbuf_cnt_nxt     = '0;
                        state_nxt        = ST_IN_FRAME;
                    end
                end

                ST_IN_FRAME: begin
                    phase_nxt = ~phase;
                    // Pair completes on phase 1; the pair is the two newest half-bits
                    if (phase) begin
                        case (sr_nxt[1:0])
                            2'b10, 2'b01: begin
                                if (dbuf_cnt == 2'd2) begin
                                    if (bit_count >= CNT_W'(MAX_BITS)) begin
                                        frame_err_nxt = 1'b1;
                                        dbuf_nxt      = '0;
                                        dbuf_cnt_nxt  = '0;
                                        state_nxt     = ST_HUNT;
                                    end else begin
                                        data_valid_nxt = 1'b1;
                                        data_out_nxt   = dbuf[1];
                                        bit_count_nxt  = bit_count + CNT_W'(1);
                                        dbuf_nxt       = {dbuf[0], sr_nxt[1]};
                                    end
                                end else begin
                                    dbuf_nxt     = {dbuf[0], sr_nxt[1]};
                                    dbuf_cnt_nxt = dbuf_cnt + 2'd1;
                                end
                            end
                            2'b00: begin
                                if (sr_nxt[5:2] == END_PAT) begin
                                    frame_end_nxt = 1'b1;
                                end else begin
                                    frame_err_nxt = 1'b1;
                                end
                                dbuf_nxt     = '0;
                                dbuf_cnt_nxt = '0;
                                state_nxt    = ST_HUNT;
                            end
                            default: begin
                                frame_err_nxt = 1'b1;
                                dbuf_nxt      = '0;
                                dbuf_cnt_nxt  = '0;
                                state_nxt     = ST_HUNT;
                            end
                        endcase
                    end
                end

                default: state_nxt = ST_HUNT;
            endcase
        end

        in_frame_nxt = (state_nxt == ST_IN_FRAME);

`ifdef DELIM_ERRCNT_EN
        err_count_nxt = err_count;
        if (frame_err_nxt && err_count != 8'hFF) begin
            err_count_nxt = err_count + 8'd1;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk_3M or posedge reset) begin
        if (reset) begin
            state        <= ST_HUNT;
            sr           <= '0;
            phase        <= 1'b0;
            dbuf         <= '0;
            dbuf_cnt     <= '0;
            master_start <= 1'b0;
            slave_start  <= 1'b0;
            data_out     <= 1'b0;
            data_valid   <= 1'b0;
            frame_end    <= 1'b0;
            frame_err    <= 1'b0;
            in_frame     <= 1'b0;
            bit_count    <= '0;
`ifdef DELIM_ERRCNT_EN
            err_count    <= '0;
`endif
        end else begin
            state        <= state_nxt;
            sr           <= sr_nxt;
            phase        <= phase_nxt;
            dbuf         <= dbuf_nxt;
            dbuf_cnt     <= dbuf_cnt_nxt;
            master_start <= master_start_nxt;
            slave_start  <= slave_start_nxt;
            data_out     <= data_out_nxt;
            data_valid   <= data_valid_nxt;
            frame_end    <= frame_end_nxt;
            frame_err    <= frame_err_nxt;
            in_frame     <= in_frame_nxt;
            bit_count    <= bit_count_nxt;
`ifdef DELIM_ERRCNT_EN
            err_count    <= err_count_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_delimiter_detect.sv
// tb_delimiter_detect: table vectors, hand sequences for reset/enable/timeout,
// and a randomized stream checked cycle by cycle against a queue-based model.

module tb_delimiter_detect;

    localparam int MAX_BITS = 300;
    localparam logic [17:0] PAT_M = 18'b111001001001000000;
    localparam logic [17:0] PAT_S = 18'b111111110110110110;

    logic       clk_3M;
    logic       reset;
    logic       rx_enable;
    logic       line_in;
    logic       master_start;
    logic       slave_start;
    logic       data_out;
    logic       data_valid;
    logic       frame_end;
    logic       frame_err;
    logic       in_frame;
    logic [8:0] bit_count;
`ifdef DELIM_ERRCNT_EN
    logic [7:0] err_count;
`endif

    delimiter_detect #(.MAX_BITS(MAX_BITS)) dut (
        .clk_3M       (clk_3M),
        .reset        (reset),
        .rx_enable    (rx_enable),
        .line_in      (line_in),
        .master_start (master_start),
        .slave_start  (slave_start),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_end    (frame_end),
        .frame_err    (frame_err),
        .in_frame     (in_frame),
        .bit_count    (bit_count)
`ifdef DELIM_ERRCNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    initial clk_3M = 1'b0;
    always #5 clk_3M = ~clk_3M;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: sliding window of the last 18 half-bits, a queue of
    // decoded-but-withheld bits, and the frame's half-bit / emitted-bit counts.
    logic hist[$];
    logic pend[$];
    bit   m_frame;
    int   m_hb;
    int   m_bc;
    int   m_ec;
    bit   e_ms, e_ss, e_dv, e_fe, e_er;
    logic e_do;

    // Observed event tallies for the table vectors
    int         o_m, o_s, o_dv, o_fe, o_er;
    logic [7:0] o_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear_window();
        hist.delete();
        repeat (18) hist.push_back(1'b0);
    endtask

    task automatic model_reset();
        model_clear_window();
        pend.delete();
        m_frame = 0;
        m_hb    = 0;
        m_bc    = 0;
        m_ec    = 0;
        e_do    = 1'b0;
    endtask

    function automatic bit win_is(input logic [17:0] pat);
        for (int i = 0; i < 18; i++) begin
            if (hist[i] !== pat[17-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_leave(input bit err);
        if (err) begin
            e_er = 1;
            if (m_ec < 255) m_ec++;
        end else begin
            e_fe = 1;
        end
        m_frame = 0;
        pend.delete();
    endtask

    task automatic model_step(input logic en, input logic b);
        logic first, second;
        e_ms = 0; e_ss = 0; e_dv = 0; e_fe = 0; e_er = 0;
        if (!en) begin
            model_clear_window();
            pend.delete();
            m_frame = 0;
        end else begin
            hist.push_back(b);
            void'(hist.pop_front());
            if (!m_frame) begin
                if (win_is(PAT_M) || win_is(PAT_S)) begin
                    e_ms    = win_is(PAT_M);
                    e_ss    = win_is(PAT_S);
                    m_frame = 1;
                    m_hb    = 0;
                    m_bc    = 0;
                    pend.delete();
                end
            end else begin
                m_hb++;
                if (m_hb % 2 == 0) begin
                    first  = hist[16];
                    second = hist[17];
                    if (first != second) begin
                        pend.push_back(first);
                        if (pend.size() > 2) begin
                            if (m_bc >= MAX_BITS) begin
                                model_leave(1);
                            end else begin
                                e_dv = 1;
                                e_do = pend.pop_front();
                                m_bc++;
                            end
                        end
                    end else if (first == 1'b0 && hist[12] == 1'b0 && hist[13] == 1'b1
                                 && hist[14] == 1'b1 && hist[15] == 1'b0) begin
                        model_leave(0);
                    end else begin
                        model_leave(1);
                    end
                end
            end
        end
    endtask

    task automatic clr_obs();
        o_m = 0; o_s = 0; o_dv = 0; o_fe = 0; o_er = 0; o_data = '0;
    endtask

    // One half-bit: drive, clock, sample #1 after the edge, compare with model
    task automatic send(input logic en, input logic b);
        rx_enable = en;
        line_in   = b;
        @(posedge clk_3M);
        #1;
        model_step(en, b);
        chk("master_start", 32'(master_start), 32'(e_ms));
        chk("slave_start",  32'(slave_start),  32'(e_ss));
        chk("data_valid",   32'(data_valid),   32'(e_dv));
        chk("frame_end",    32'(frame_end),    32'(e_fe));
        chk("frame_err",    32'(frame_err),    32'(e_er));
        chk("in_frame",     32'(in_frame),     32'(m_frame));
        chk("bit_count",    32'(bit_count),    32'(m_bc));
        if (e_dv) chk("data_out", 32'(data_out), 32'(e_do));
`ifdef DELIM_ERRCNT_EN
        chk("err_count",    32'(err_count),    32'(m_ec));
`endif
        if (master_start) o_m++;
        if (slave_start)  o_s++;
        if (frame_end)    o_fe++;
        if (frame_err)    o_er++;
        if (data_valid) begin
            o_dv++;
            o_data = {o_data[6:0], data_out};
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(1'b1, v[i]);
    endtask

    typedef struct {
        string       name;
        logic [63:0] stim;
        int          len;
        int          m;
        int          s;
        int          dv;
        logic [7:0]  data;
        int          fe;
        int          er;
        int          bc;
    } vec_t;

    vec_t vt[5];

    task automatic apply_vec(input int k);
        logic [63:0] st;
        st = vt[k].stim;
        send(1'b0, 1'b0);
        clr_obs();
        for (int i = vt[k].len - 1; i >= 0; i--) send(1'b1, st[i]);
        chk({vt[k].name, ".master"},   32'(o_m),       32'(vt[k].m));
        chk({vt[k].name, ".slave"},    32'(o_s),       32'(vt[k].s));
        chk({vt[k].name, ".n_valid"},  32'(o_dv),      32'(vt[k].dv));
        chk({vt[k].name, ".data"},     32'(o_data),    32'(vt[k].data));
        chk({vt[k].name, ".end"},      32'(o_fe),      32'(vt[k].fe));
        chk({vt[k].name, ".err"},      32'(o_er),      32'(vt[k].er));
        chk({vt[k].name, ".bitcount"}, 32'(bit_count), 32'(vt[k].bc));
        chk({vt[k].name, ".hunt"},     32'(in_frame),  32'd0);
    endtask

    initial begin
        vt[0] = '{"master_1011", 64'({PAT_M, 8'b10011010, 4'b0110, 2'b00}), 32,
                  1, 0, 4, 8'b00001011, 1, 0, 4};
        vt[1] = '{"slave_00",    64'({PAT_S, 4'b0101, 4'b0110, 2'b00}), 28,
                  0, 1, 2, 8'b00000000, 1, 0, 2};
        vt[2] = '{"pair11",      64'({PAT_M, 2'b10, 2'b11}), 22,
                  1, 0, 0, 8'b00000000, 0, 1, 0};
        vt[3] = '{"bad00",       64'({PAT_M, 6'b101000}), 24,
                  1, 0, 0, 8'b00000000, 0, 1, 0};
        vt[4] = '{"slave_in_data", 64'({PAT_S, 2'b10, 17'b11111111011011011}), 37,
                  0, 1, 0, 8'b00000000, 0, 1, 0};

        reset     = 1'b1;
        rx_enable = 1'b0;
        line_in   = 1'b0;
        model_reset();
        #1;
        chk("rst.master_start", 32'(master_start), 32'd0);
        chk("rst.slave_start",  32'(slave_start),  32'd0);
        chk("rst.data_valid",   32'(data_valid),   32'd0);
        chk("rst.frame_end",    32'(frame_end),    32'd0);
        chk("rst.frame_err",    32'(frame_err),    32'd0);
        chk("rst.in_frame",     32'(in_frame),     32'd0);
        chk("rst.bit_count",    32'(bit_count),    32'd0);
        @(posedge clk_3M);
        #1;
        reset = 1'b0;

        for (int k = 0; k < 5; k++) apply_vec(k);

        // Length timeout: 302 valid pairs emit 300 bits, the 303rd errors out
        send(1'b0, 1'b0);
        clr_obs();
        send_bits(32'(PAT_M), 18);
        repeat (302) send_bits(32'b10, 2);
        chk("timeout.n_valid_before", 32'(o_dv),      32'd300);
        chk("timeout.err_before",     32'(o_er),      32'd0);
        chk("timeout.bitcount",       32'(bit_count), 32'd300);
        send_bits(32'b10, 2);
        chk("timeout.err_pulse",      32'(frame_err), 32'd1);
        chk("timeout.n_valid",        32'(o_dv),      32'd300);
        chk("timeout.bitcount_sat",   32'(bit_count), 32'd300);
        chk("timeout.hunt",           32'(in_frame),  32'd0);

        // Async reset mid-frame clears outputs before the next edge
        send(1'b0, 1'b0);
        send_bits(32'(PAT_M), 18);
        repeat (4) send_bits(32'b10, 2);
        chk("midrst.bitcount_pre", 32'(bit_count), 32'd2);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst.in_frame",  32'(in_frame),  32'd0);
        chk("midrst.bit_count", 32'(bit_count), 32'd0);
        chk("midrst.data_out",  32'(data_out),  32'd0);
        @(posedge clk_3M);
        #1;
        reset = 1'b0;
        model_reset();
        apply_vec(0);

        // rx_enable low mid-frame: back to HUNT, bit_count holds, no pulses
        send(1'b0, 1'b0);
        send_bits(32'(PAT_M), 18);
        repeat (4) send_bits(32'b01, 2);
        clr_obs();
        send(1'b0, 1'b1);
        chk("rxen.in_frame",  32'(in_frame),  32'd0);
        chk("rxen.bit_count", 32'(bit_count), 32'd2);
        chk("rxen.pulses",    32'(o_m + o_s + o_dv + o_fe + o_er), 32'd0);
        apply_vec(1);

        // Randomized stream against the model
        for (int cyc = 0; cyc < 6000; ) begin
            int kind;
            int n;
            logic b;
            kind = int'($urandom_range(0, 9));
            case (kind)
                0: begin send_bits(32'(PAT_M), 18); cyc += 18; end
                1: begin send_bits(32'(PAT_S), 18); cyc += 18; end
                2, 3, 4: begin
                    n = int'($urandom_range(1, 8));
                    for (int i = 0; i < n; i++) begin
                        b = 1'($urandom_range(0, 1));
                        send_bits(32'({b, ~b}), 2);
                    end
                    cyc += 2 * n;
                end
                5: begin send_bits(32'b011000, 6); cyc += 6; end
                6: begin
                    n = int'($urandom_range(1, 6));
                    for (int i = 0; i < n; i++) send(1'b1, 1'($urandom_range(0, 1)));
                    cyc += n;
                end
                7: begin
                    n = int'($urandom_range(1, 3));
                    for (int i = 0; i < n; i++) send(1'b0, 1'($urandom_range(0, 1)));
                    cyc += n;
                end
                8: begin
                    n = int'($urandom_range(1, 4));
                    for (int i = 0; i < n; i++) send(1'b1, 1'b0);
                    cyc += n;
                end
                default: begin
                    b = 1'($urandom_range(0, 1));
                    send_bits(32'({b, b}), 2);
                    cyc += 2;
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
